// File: rtl/mac_tx_arb.sv
// Frame-granular round-robin arbiter feeding the MAC TX FIFO write port.
// A grant lasts a whole frame; frames longer than MAX_LEN are cut with EOP+ERR and the rest drained.
module mac_tx_arb #(
    parameter int NREQ    = 2,
    parameter int MAX_LEN = 1518
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NREQ-1:0]                        req_valid,
    input  logic [11*NREQ-1:0]                     req_data,
    output logic [NREQ-1:0]                        req_ready,
    input  logic                                   fifo_full,
    output logic                                   fifo_write,
    output logic [10:0]                            fifo_wdata,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gnt_id,
    output logic                                   busy,
    output logic                                   frm_done,
    output logic                                   frm_trunc
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] LAST = LW'(MAX_LEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr, rr_ptr_nxt, gnt_nxt, winner;
    logic [LW-1:0]   len, len_nxt;
    logic            found;
    logic            sel_valid;
    logic [10:0]     sel_word;
    logic [NREQ-1:0] gnt_onehot;
    logic            last_word;
    logic            accept;
    logic            done_nxt, trunc_nxt;

    // Rotating priority scan: offset k from rr_ptr, first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (i == (int'(rr_ptr) + k) % NREQ) && req_valid[i]) begin
                    found  = 1'b1;
                    winner = GW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_valid  = 1'b0;
        sel_word   = '0;
        gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == GW'(i)) begin
                sel_valid     = req_valid[i];
                sel_word      = req_data[11*i +: 11];
                gnt_onehot[i] = 1'b1;
            end
        end
    end

    assign last_word = (len == LAST);

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        gnt_nxt    = gnt_id;
        len_nxt    = len;
        done_nxt   = 1'b0;
        trunc_nxt  = 1'b0;
        req_ready  = '0;
        fifo_write = 1'b0;
        fifo_wdata = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt    = winner;
                    rr_ptr_nxt = (winner == GW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    len_nxt    = '0;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                req_ready     = gnt_onehot & {NREQ{~fifo_full}};
                accept        = sel_valid & ~fifo_full;
                fifo_write    = accept;
                fifo_wdata    = sel_word;
                fifo_wdata[9] = (len == '0);
                // A word that already ends the frame at the limit is a normal completion, not a cut.
                if (last_word && !sel_word[10]) begin
                    fifo_wdata[10] = 1'b1;
                    fifo_wdata[8]  = 1'b1;
                end
                if (accept) begin
                    len_nxt = len + 1'b1;
                    if (sel_word[10]) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (last_word) begin
                        state_nxt = DRAIN;
                        trunc_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                req_ready = gnt_onehot;
                if (sel_valid && sel_word[10]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            len       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            frm_done  <= 1'b0;
            frm_trunc <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            len       <= len_nxt;
            gnt_id    <= gnt_nxt;
            busy      <= (state_nxt != IDLE);
            frm_done  <= done_nxt;
            frm_trunc <= trunc_nxt;
        end
    end

endmodule
